// File: rtl/rom_seq_controller_if.sv
// Command, table-programming and status signals of the table-driven sequencer.
// The design takes the slave modport. The driving side takes the master modport.
interface rom_seq_controller_if #(
  parameter int unsigned STATE_W = 3
);
  logic               cmd_valid;
  logic [1:0]         cmd_op;
  logic [STATE_W-1:0] cmd_data;
  logic [STATE_W-1:0] term_state;
  logic               wr_en;
  logic [STATE_W-1:0] wr_addr;
  logic [STATE_W-1:0] wr_data;
  logic               wr_ack;
  logic [STATE_W-1:0] state_out;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output cmd_valid, cmd_op, cmd_data, term_state,
    output wr_en, wr_addr, wr_data,
    input  wr_ack, state_out, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, term_state,
    input  wr_en, wr_addr, wr_data,
    output wr_ack, state_out, busy, done, err
  );
endinterface

// File: rtl/rom_seq_controller.sv
// Table-driven next-state sequencer: writable lookup table, state register,
// START/STOP/STEP/LOAD control and a watchdog that aborts non-terminating runs.
module rom_seq_controller #(
  parameter int unsigned STATE_W = 3
) (
  input logic                 clk,
  input logic                 rst,
  rom_seq_controller_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** STATE_W;
  localparam logic [STATE_W:0] WD_LIMIT = {1'b1, {STATE_W{1'b0}}};

  typedef enum logic {
    S_IDLE,
    S_RUN
  } fsm_t;

  typedef enum logic [1:0] {
    OP_START = 2'b00,
    OP_STOP  = 2'b01,
    OP_STEP  = 2'b10,
    OP_LOAD  = 2'b11
  } op_t;

  fsm_t fsm_q, fsm_d;

  logic [STATE_W-1:0] tbl [DEPTH];
  logic [STATE_W-1:0] nxt;
  logic [STATE_W-1:0] state_q, state_d;
  logic [STATE_W:0]   wd_q, wd_d, wd_inc;
  logic               busy_q;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               ack_q, ack_d;
  logic               tbl_we;

  logic is_start, is_stop, is_step, is_load;
  logic term_hit, wd_expire, illegal_in_run;

  assign nxt       = tbl[state_q];
  assign wd_inc    = wd_q + 1'b1;
  assign term_hit  = (nxt == bus.term_state);
  assign wd_expire = (wd_inc == WD_LIMIT);

  assign is_start = bus.cmd_valid && (bus.cmd_op == OP_START);
  assign is_stop  = bus.cmd_valid && (bus.cmd_op == OP_STOP);
  assign is_step  = bus.cmd_valid && (bus.cmd_op == OP_STEP);
  assign is_load  = bus.cmd_valid && (bus.cmd_op == OP_LOAD);

  assign illegal_in_run = bus.wr_en || is_start || is_step || is_load;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q <= S_IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // Next-state logic: terminal hit, STOP and watchdog expiry all end a run
  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      S_IDLE: begin
        if (is_start) begin
          fsm_d = S_RUN;
        end
      end
      S_RUN: begin
        if (term_hit || is_stop || wd_expire) begin
          fsm_d = S_IDLE;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  // Output/datapath logic. The terminal check comes first so that a terminal
  // hit suppresses STOP, watchdog and illegal-activity errors on that edge.
  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    ack_d   = 1'b0;
    tbl_we  = 1'b0;
    unique case (fsm_q)
      S_IDLE: begin
        if (is_start) begin
          wd_d = '0;
        end else if (is_step) begin
          state_d = nxt;
        end else if (is_load) begin
          state_d = bus.cmd_data;
        end
        if (bus.wr_en) begin
          tbl_we = 1'b1;
          ack_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (term_hit) begin
          state_d = nxt;
          wd_d    = wd_inc;
          done_d  = 1'b1;
        end else if (is_stop) begin
          state_d = state_q;
        end else begin
          state_d = nxt;
          wd_d    = wd_inc;
          err_d   = wd_expire;
        end
        if (!term_hit && illegal_in_run) begin
          err_d = 1'b1;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
      wd_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      busy_q  <= (fsm_d == S_RUN);
      done_q  <= done_d;
      err_q   <= err_d;
      ack_q   <= ack_d;
    end
  end

  // Reset restores the identity-plus-one table, i.e. a plain wrapping counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tbl[STATE_W'(i)] <= STATE_W'(i + 1);
      end
    end else if (tbl_we) begin
      tbl[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign bus.state_out = state_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.wr_ack    = ack_q;
endmodule

// File: tb/tb_rom_seq_controller.sv
// Scoreboard bench for rom_seq_controller: stimulus queues expected output
// snapshots, a negedge monitor compares them whenever the outputs change.
module tb_rom_seq_controller;
  localparam int unsigned SW = 3;
  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_STEP  = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

  typedef struct packed {
    logic [SW-1:0] st;
    logic          busy;
    logic          done;
    logic          err;
    logic          ack;
  } snap_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rom_seq_controller_if #(.STATE_W(SW)) bus ();

  rom_seq_controller #(.STATE_W(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  snap_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    n_ev  = 0;

  function automatic snap_t sample();
    snap_t s;
    s.st   = bus.state_out;
    s.busy = bus.busy;
    s.done = bus.done;
    s.err  = bus.err;
    s.ack  = bus.wr_ack;
    return s;
  endfunction

  task automatic ex(input int st, input bit b, input bit d, input bit e, input bit a);
    snap_t s;
    s.st   = SW'(st);
    s.busy = b;
    s.done = d;
    s.err  = e;
    s.ack  = a;
    exp_q.push_back(s);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got %0d required %0d", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [1:0] op, input int data);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = SW'(data);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wr(input int addr, input int data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = SW'(addr);
    bus.wr_data = SW'(data);
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_%s got %0d pending events required 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) tick();
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1;
    #1;
    tick();
    tick();
    rst = 1'b0;
    check({name, "_state"}, 32'(bus.state_out), 0);
    check({name, "_busy"},  32'(bus.busy),      0);
    check({name, "_done"},  32'(bus.done),      0);
    check({name, "_err"},   32'(bus.err),       0);
    check({name, "_ack"},   32'(bus.wr_ack),    0);
  endtask

  // Monitor: every change of the output snapshot is one DUT event
  initial begin
    snap_t prev, cur, e;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = sample();
      if (rst) begin
        prev = cur;
      end else if (cur !== prev) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_event got st=%0d busy=%b done=%b err=%b ack=%b required no change",
                   cur.st, cur.busy, cur.done, cur.err, cur.ack);
        end else begin
          e = exp_q.pop_front();
          n_ev++;
          if (cur !== e) begin
            n_bad++;
            $display("FAIL event%0d got st=%0d busy=%b done=%b err=%b ack=%b required st=%0d busy=%b done=%b err=%b ack=%b",
                     n_ev, cur.st, cur.busy, cur.done, cur.err, cur.ack,
                     e.st, e.busy, e.done, e.err, e.ack);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = OP_START;
    bus.cmd_data   = '0;
    bus.term_state = SW'(7);
    bus.wr_en      = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;

    do_reset("rst_init");

    // Default table: 0 -> 1..7, done with state 7
    cmd(OP_LOAD, 0);
    ex(0, 1, 0, 0, 0);
    for (int i = 1; i <= 6; i++) ex(i, 1, 0, 0, 0);
    ex(7, 0, 1, 0, 0);
    ex(7, 0, 0, 0, 0);
    cmd(OP_START, 0);
    drain("default_run");

    // Non-terminating 2 <-> 5 loop aborted by the watchdog after 8 advances
    ex(7, 0, 0, 0, 1); ex(7, 0, 0, 0, 0);
    wr(2, 5);
    drain("wr2");
    ex(7, 0, 0, 0, 1); ex(7, 0, 0, 0, 0);
    wr(5, 2);
    drain("wr5");
    ex(2, 0, 0, 0, 0);
    cmd(OP_LOAD, 2);
    ex(2, 1, 0, 0, 0);
    for (int k = 1; k <= 7; k++) ex((k % 2 == 1) ? 5 : 2, 1, 0, 0, 0);
    ex(2, 0, 0, 1, 0);
    ex(2, 0, 0, 0, 0);
    cmd(OP_START, 0);
    drain("loop_run");

    // Terminal 0 reached on the 8th advance beats the watchdog
    do_reset("rst_wrap");
    bus.term_state = SW'(0);
    cmd(OP_LOAD, 0);
    ex(0, 1, 0, 0, 0);
    for (int i = 1; i <= 7; i++) ex(i, 1, 0, 0, 0);
    ex(0, 0, 1, 0, 0);
    ex(0, 0, 0, 0, 0);
    cmd(OP_START, 0);
    drain("wrap_run");

    // STOP while state 3: hold, no done
    do_reset("rst_stop");
    bus.term_state = SW'(7);
    ex(0, 1, 0, 0, 0); ex(1, 1, 0, 0, 0); ex(2, 1, 0, 0, 0); ex(3, 1, 0, 0, 0);
    ex(3, 0, 0, 0, 0);
    cmd(OP_START, 0);
    repeat (3) tick();
    cmd(OP_STOP, 0);
    drain("stop_at3");

    // STOP colliding with the terminal hit: terminal wins
    ex(0, 0, 0, 0, 0);
    cmd(OP_LOAD, 0);
    ex(0, 1, 0, 0, 0);
    for (int i = 1; i <= 6; i++) ex(i, 1, 0, 0, 0);
    ex(7, 0, 1, 0, 0);
    ex(7, 0, 0, 0, 0);
    cmd(OP_START, 0);
    repeat (6) tick();
    cmd(OP_STOP, 0);
    drain("stop_collide");

    // Write during RUN: err pulse, no ack, table untouched
    ex(0, 0, 0, 0, 0);
    cmd(OP_LOAD, 0);
    ex(0, 1, 0, 0, 0); ex(1, 1, 0, 0, 0); ex(2, 1, 0, 1, 0);
    for (int i = 3; i <= 6; i++) ex(i, 1, 0, 0, 0);
    ex(7, 0, 1, 0, 0);
    ex(7, 0, 0, 0, 0);
    cmd(OP_START, 0);
    tick();
    bus.wr_en   = 1'b1;
    bus.wr_addr = SW'(4);
    bus.wr_data = SW'(0);
    tick();
    bus.wr_en = 1'b0;
    drain("run_write");

    // STEP in IDLE onto term_state gives no done; STOP in IDLE is silent
    ex(4, 0, 0, 0, 0);
    cmd(OP_LOAD, 4);
    bus.term_state = SW'(5);
    ex(5, 0, 0, 0, 0);
    cmd(OP_STEP, 0);
    cmd(OP_STOP, 0);
    drain("idle_step");

    // Write and STEP on the same edge: STEP sees the old table[5]
    ex(6, 0, 0, 0, 1); ex(6, 0, 0, 0, 0);
    bus.wr_en   = 1'b1;
    bus.wr_addr = SW'(5);
    bus.wr_data = SW'(0);
    cmd(OP_STEP, 0);
    bus.wr_en = 1'b0;
    drain("wr_step");
    ex(5, 0, 0, 0, 0);
    cmd(OP_LOAD, 5);
    ex(0, 0, 0, 0, 0);
    cmd(OP_STEP, 0);
    drain("new_entry");

    // Asynchronous reset mid-run restores the default table
    do_reset("rst_pre_async");
    bus.term_state = SW'(7);
    ex(0, 0, 0, 0, 1); ex(0, 0, 0, 0, 0);
    wr(1, 6);
    drain("wr1");
    ex(0, 1, 0, 0, 0); ex(1, 1, 0, 0, 0);
    cmd(OP_START, 0);
    tick();
    @(negedge clk);
    #1;
    check("busy_before_async", 32'(bus.busy), 1);
    rst = 1'b1;
    #1;
    check("async_state", 32'(bus.state_out), 0);
    check("async_busy",  32'(bus.busy),      0);
    check("async_done",  32'(bus.done),      0);
    check("async_err",   32'(bus.err),       0);
    check("async_pending", 32'(exp_q.size()), 0);
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    ex(1, 0, 0, 0, 0);
    cmd(OP_LOAD, 1);
    ex(2, 0, 0, 0, 0);
    cmd(OP_STEP, 0);
    drain("post_async");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
